// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - receive frame controller: address filter, length checks, verdict, stats
module rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_LEN    = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error,
    input  logic [47:0]           local_mac,
    input  logic [15:0]           max_len,
    input  logic                  promisc,
    input  logic                  accept_mcast,
    output logic                  status_valid,
    output logic                  status_accept,
    output logic [2:0]            status_reason,
    output logic [15:0]           status_len,
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  cnt_good,
    output logic [CNT_WIDTH-1:0]  cnt_bad,
    output logic [CNT_WIDTH-1:0]  cnt_runt,
    output logic [CNT_WIDTH-1:0]  cnt_giant,
    output logic [CNT_WIDTH-1:0]  cnt_filtered
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DA = 2'd1, S_BODY = 2'd2} state_t;

    localparam logic [2:0]  R_OK       = 3'd0;
    localparam logic [2:0]  R_ERROR    = 3'd1;
    localparam logic [2:0]  R_RUNT     = 3'd2;
    localparam logic [2:0]  R_GIANT    = 3'd3;
    localparam logic [2:0]  R_FILTERED = 3'd4;
    localparam logic [2:0]  R_ABORT    = 3'd5;
    localparam logic [15:0] MIN_LEN_W  = 16'(MIN_LEN);

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [2:0]  da_idx_q;
    logic        err_q, uc_q, bc_q, mc_q;

    logic [7:0]  in_byte;
    logic        sop_beat, tracked, abort_beat, eop_beat;
    logic [2:0]  cmp_idx;
    logic [7:0]  mac_byte;
    logic        byte_is_mac, byte_is_bc;

    logic [15:0] cur_len;
    logic        cur_err, cur_uc, cur_bc, cur_mc, cur_da_done;
    logic [2:0]  nxt_idx;
    logic        addr_ok;
    logic [2:0]  verdict;

    logic        first_v, second_v;
    logic [2:0]  first_r, second_r;
    logic [15:0] first_l, second_l;
    logic        pend_v_q, pend_v_d;
    logic [2:0]  pend_r_q, pend_r_d;
    logic [15:0] pend_l_q, pend_l_d;
    logic        st_v_q, st_v_d, st_a_q, st_a_d;
    logic [2:0]  st_r_q, st_r_d;
    logic [15:0] st_l_q, st_l_d;
    logic        out_error_d;

    logic                  osop_q, oeop_q, oval_q, oerr_q;
    logic [DATA_WIDTH-1:0] odata_q;
    logic [CNT_WIDTH-1:0]  good_q, bad_q, runt_q, giant_q, filt_q;
    logic                  hit_good, hit_bad, hit_runt, hit_giant, hit_filt;

    assign in_byte    = in_data[7:0];
    // A sop always opens a frame; other beats only count while a frame is open.
    assign sop_beat   = in_valid & in_startofpacket;
    assign tracked    = in_valid & (in_startofpacket | (state_q != S_IDLE));
    assign abort_beat = sop_beat & (state_q != S_IDLE);
    assign eop_beat   = tracked & in_endofpacket;

    // Select the station-address byte that lines up with the current DA byte
    always_comb begin
        mac_byte = 8'h00;
        cmp_idx  = sop_beat ? 3'd0 : da_idx_q;
        case (cmp_idx)
            3'd0:    mac_byte = local_mac[47:40];
            3'd1:    mac_byte = local_mac[39:32];
            3'd2:    mac_byte = local_mac[31:24];
            3'd3:    mac_byte = local_mac[23:16];
            3'd4:    mac_byte = local_mac[15:8];
            3'd5:    mac_byte = local_mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    assign byte_is_mac = (in_byte == mac_byte);
    assign byte_is_bc  = (in_byte == 8'hFF);

    // Frame attributes including the current beat, so the verdict is ready on the eop beat
    always_comb begin
        cur_len     = len_q;
        cur_err     = err_q;
        cur_uc      = uc_q;
        cur_bc      = bc_q;
        cur_mc      = mc_q;
        cur_da_done = (state_q == S_BODY);
        nxt_idx     = da_idx_q;
        if (sop_beat) begin
            cur_len     = 16'd1;
            cur_err     = in_error;
            cur_uc      = byte_is_mac;
            cur_bc      = byte_is_bc;
            cur_mc      = in_byte[0];
            cur_da_done = 1'b0;
            nxt_idx     = 3'd1;
        end else if (state_q != S_IDLE) begin
            cur_len = (&len_q) ? len_q : len_q + 16'd1;
            cur_err = err_q | in_error;
            if (state_q == S_DA) begin
                cur_uc      = uc_q & byte_is_mac;
                cur_bc      = bc_q & byte_is_bc;
                cur_da_done = (da_idx_q == 3'd5);
                nxt_idx     = da_idx_q + 3'd1;
            end
        end
    end

    // Verdict with priority ERROR > RUNT > GIANT > FILTERED > OK
    always_comb begin
        addr_ok = promisc | cur_uc | cur_bc | (cur_mc & accept_mcast);
        verdict = R_OK;
        if (cur_err)
            verdict = R_ERROR;
        else if (!cur_da_done || (cur_len < MIN_LEN_W))
            verdict = R_RUNT;
        else if (cur_len > max_len)
            verdict = R_GIANT;
        else if (!addr_ok)
            verdict = R_FILTERED;
    end

    // FSM state register
    always_ff @(posedge mac_clk) begin
        if (mac_rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: eop always closes, sop always (re)opens, DA ends after byte 5
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (in_startofpacket)
                        state_d = in_endofpacket ? S_IDLE : S_DA;
                end
                S_DA, S_BODY: begin
                    if (in_endofpacket)
                        state_d = S_IDLE;
                    else if (in_startofpacket)
                        state_d = S_DA;
                    else if ((state_q == S_DA) && (da_idx_q == 3'd5))
                        state_d = S_BODY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Per-frame length, DA index and match/error flags
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            len_q    <= 16'd0;
            da_idx_q <= 3'd0;
            err_q    <= 1'b0;
            uc_q     <= 1'b0;
            bc_q     <= 1'b0;
            mc_q     <= 1'b0;
        end else if (tracked) begin
            len_q    <= cur_len;
            da_idx_q <= nxt_idx;
            err_q    <= cur_err;
            uc_q     <= cur_uc;
            bc_q     <= cur_bc;
            mc_q     <= cur_mc;
        end
    end

    // FSM outputs: status ordering through a one-entry pending slot, plus the eop error override.
    // An abort and the 1-byte frame that caused it both arise on one beat; the abort leaves first.
    // The pending slot can only stay occupied while the FSM is idle, so at most one new status
    // arrives whenever it is full.
    always_comb begin
        first_v  = abort_beat | eop_beat;
        first_r  = abort_beat ? R_ABORT : (eop_beat ? verdict : 3'd0);
        first_l  = abort_beat ? len_q : (eop_beat ? cur_len : 16'd0);
        second_v = abort_beat & eop_beat;
        second_r = second_v ? verdict : 3'd0;
        second_l = second_v ? cur_len : 16'd0;
        if (pend_v_q) begin
            st_v_d   = 1'b1;
            st_r_d   = pend_r_q;
            st_l_d   = pend_l_q;
            pend_v_d = first_v;
            pend_r_d = first_r;
            pend_l_d = first_l;
        end else begin
            st_v_d   = first_v;
            st_r_d   = first_r;
            st_l_d   = first_l;
            pend_v_d = second_v;
            pend_r_d = second_r;
            pend_l_d = second_l;
        end
        st_a_d      = st_v_d & (st_r_d == R_OK);
        out_error_d = in_error | (eop_beat & (verdict != R_OK));
    end

    // Registered status, pending slot and re-timed stream
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            st_v_q   <= 1'b0;
            st_a_q   <= 1'b0;
            st_r_q   <= 3'd0;
            st_l_q   <= 16'd0;
            pend_v_q <= 1'b0;
            pend_r_q <= 3'd0;
            pend_l_q <= 16'd0;
            osop_q   <= 1'b0;
            oeop_q   <= 1'b0;
            oval_q   <= 1'b0;
            oerr_q   <= 1'b0;
            odata_q  <= '0;
        end else begin
            st_v_q   <= st_v_d;
            st_a_q   <= st_a_d;
            st_r_q   <= st_r_d;
            st_l_q   <= st_l_d;
            pend_v_q <= pend_v_d;
            pend_r_q <= pend_r_d;
            pend_l_q <= pend_l_d;
            osop_q   <= in_startofpacket;
            oeop_q   <= in_endofpacket;
            oval_q   <= in_valid;
            oerr_q   <= out_error_d;
            odata_q  <= in_data;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic hit);
        return (hit && !(&v)) ? v + 1'b1 : v;
    endfunction

    assign hit_good  = st_v_q & (st_r_q == R_OK);
    assign hit_bad   = st_v_q & ((st_r_q == R_ERROR) | (st_r_q == R_ABORT));
    assign hit_runt  = st_v_q & (st_r_q == R_RUNT);
    assign hit_giant = st_v_q & (st_r_q == R_GIANT);
    assign hit_filt  = st_v_q & (st_r_q == R_FILTERED);

    // Saturating statistics; clear wins over a coincident increment
    always_ff @(posedge mac_clk) begin
        if (mac_rst || stats_clr) begin
            good_q  <= '0;
            bad_q   <= '0;
            runt_q  <= '0;
            giant_q <= '0;
            filt_q  <= '0;
        end else begin
            good_q  <= sat_inc(good_q, hit_good);
            bad_q   <= sat_inc(bad_q, hit_bad);
            runt_q  <= sat_inc(runt_q, hit_runt);
            giant_q <= sat_inc(giant_q, hit_giant);
            filt_q  <= sat_inc(filt_q, hit_filt);
        end
    end

    assign out_startofpacket = osop_q;
    assign out_endofpacket   = oeop_q;
    assign out_valid         = oval_q;
    assign out_data          = odata_q;
    assign out_error         = oerr_q;
    assign status_valid      = st_v_q;
    assign status_accept     = st_a_q;
    assign status_reason     = st_r_q;
    assign status_len        = st_l_q;
    assign cnt_good          = good_q;
    assign cnt_bad           = bad_q;
    assign cnt_runt          = runt_q;
    assign cnt_giant         = giant_q;
    assign cnt_filtered      = filt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

    localparam int CW = 4;
    localparam logic [47:0] MAC = 48'h020000000001;
    localparam logic [47:0] OTH = 48'h020000000002;
    localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] MC  = 48'h01005E000001;

    logic          mac_clk = 1'b0;
    logic          mac_rst;
    logic          in_startofpacket, in_endofpacket, in_valid, in_error;
    logic [7:0]    in_data;
    logic          out_startofpacket, out_endofpacket, out_valid, out_error;
    logic [7:0]    out_data;
    logic [47:0]   local_mac;
    logic [15:0]   max_len;
    logic          promisc, accept_mcast;
    logic          status_valid, status_accept;
    logic [2:0]    status_reason;
    logic [15:0]   status_len;
    logic          stats_clr;
    logic [CW-1:0] cnt_good, cnt_bad, cnt_runt, cnt_giant, cnt_filtered;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] obs_oerr, obs_oeop, obs_sv, obs_acc, obs_rsn, obs_len;

    rx_frame_ctrl #(.DATA_WIDTH(8), .MIN_LEN(64), .CNT_WIDTH(CW)) dut (
        .mac_clk(mac_clk), .mac_rst(mac_rst),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
        .local_mac(local_mac), .max_len(max_len), .promisc(promisc), .accept_mcast(accept_mcast),
        .status_valid(status_valid), .status_accept(status_accept),
        .status_reason(status_reason), .status_len(status_len),
        .stats_clr(stats_clr),
        .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_runt(cnt_runt),
        .cnt_giant(cnt_giant), .cnt_filtered(cnt_filtered)
    );

    always #5 mac_clk = ~mac_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [47:0] da, input int i);
        if (i < 6) return da[47-8*i -: 8];
        return 8'(i);
    endfunction

    task automatic put_beat(input logic sop, input logic eop, input logic [7:0] d, input logic err);
        @(negedge mac_clk);
        in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop; in_data = d; in_error = err;
    endtask

    task automatic idle_beat();
        @(negedge mac_clk);
        in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_data = 8'h00; in_error = 1'b0;
    endtask

    task automatic sample();
        obs_oerr = 32'(out_error);
        obs_oeop = 32'(out_endofpacket);
        obs_sv   = 32'(status_valid);
        obs_acc  = 32'(status_accept);
        obs_rsn  = 32'(status_reason);
        obs_len  = 32'(status_len);
    endtask

    task automatic send_bytes(input logic [47:0] da, input int from, input int upto,
                              input int len, input int err_at, input logic stall);
        for (int i = from; i < upto; i++) begin
            put_beat(i == 0, i == len - 1, fbyte(da, i), i == err_at);
            if (stall && i != upto - 1) idle_beat();
        end
    endtask

    task automatic send_frame(input logic [47:0] da, input int len, input int err_at, input logic stall);
        send_bytes(da, 0, len, len, err_at, stall);
        idle_beat();
        sample();
    endtask

    task automatic exp_status(input string tag, input int acc, input int rsn, input int len);
        chk({tag, ".valid"}, obs_sv, 32'd1);
        chk({tag, ".accept"}, obs_acc, 32'(acc));
        chk({tag, ".reason"}, obs_rsn, 32'(rsn));
        chk({tag, ".len"}, obs_len, 32'(len));
    endtask

    task automatic exp_counts(input string tag, input int g, input int b, input int r, input int gi, input int f);
        chk({tag, ".cnt_good"}, 32'(cnt_good), 32'(g));
        chk({tag, ".cnt_bad"}, 32'(cnt_bad), 32'(b));
        chk({tag, ".cnt_runt"}, 32'(cnt_runt), 32'(r));
        chk({tag, ".cnt_giant"}, 32'(cnt_giant), 32'(gi));
        chk({tag, ".cnt_filtered"}, 32'(cnt_filtered), 32'(f));
    endtask

    initial begin
        mac_rst = 1'b1; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_data = 8'h00; in_error = 1'b0; local_mac = MAC; max_len = 16'd1518;
        promisc = 1'b0; accept_mcast = 1'b0; stats_clr = 1'b0;
        repeat (3) @(negedge mac_clk);
        mac_rst = 1'b0;
        chk("rst.status_valid", 32'(status_valid), 32'd0);
        chk("rst.status_len", 32'(status_len), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_error", 32'(out_error), 32'd0);
        exp_counts("rst", 0, 0, 0, 0, 0);

        send_frame(MAC, 64, -1, 1'b0);
        chk("good.out_eop", obs_oeop, 32'd1);
        chk("good.out_error", obs_oerr, 32'd0);
        exp_status("good", 1, 0, 64);
        idle_beat();
        chk("good.cnt_good", 32'(cnt_good), 32'd1);

        send_frame(OTH, 64, -1, 1'b0);
        chk("filt.out_error", obs_oerr, 32'd1);
        exp_status("filt", 0, 4, 64);
        promisc = 1'b1;
        send_frame(OTH, 64, -1, 1'b0);
        chk("promisc.out_error", obs_oerr, 32'd0);
        exp_status("promisc", 1, 0, 64);
        promisc = 1'b0;

        send_frame(BC, 64, -1, 1'b0);
        exp_status("bcast", 1, 0, 64);
        send_frame(MC, 64, -1, 1'b0);
        exp_status("mcast_off", 0, 4, 64);
        accept_mcast = 1'b1;
        send_frame(BC, 64, -1, 1'b0);
        exp_status("bcast_mc", 1, 0, 64);
        send_frame(MC, 64, -1, 1'b0);
        exp_status("mcast_on", 1, 0, 64);
        accept_mcast = 1'b0;

        send_frame(MAC, 40, 20, 1'b0);
        exp_status("err40", 0, 1, 40);
        send_frame(MAC, 40, -1, 1'b0);
        exp_status("runt40", 0, 2, 40);
        send_frame(MAC, 63, -1, 1'b0);
        exp_status("runt63", 0, 2, 63);
        send_frame(MAC, 1519, -1, 1'b0);
        chk("giant.out_error", obs_oerr, 32'd1);
        exp_status("giant", 0, 3, 1519);
        send_frame(MAC, 1518, -1, 1'b0);
        exp_status("maxlen", 1, 0, 1518);
        idle_beat();
        exp_counts("grp1", 6, 1, 2, 1, 2);

        stats_clr = 1'b1;
        idle_beat();
        stats_clr = 1'b0;
        idle_beat();
        exp_counts("clr", 0, 0, 0, 0, 0);

        send_bytes(MAC, 0, 30, 0, -1, 1'b0);
        put_beat(1'b1, 1'b0, fbyte(MAC, 0), 1'b0);
        put_beat(1'b0, 1'b0, fbyte(MAC, 1), 1'b0);
        sample();
        exp_status("abort", 0, 5, 30);
        send_bytes(MAC, 2, 64, 64, -1, 1'b0);
        idle_beat();
        sample();
        exp_status("after_abort", 1, 0, 64);
        idle_beat();
        chk("abort.cnt_bad", 32'(cnt_bad), 32'd1);
        chk("abort.cnt_good", 32'(cnt_good), 32'd1);

        send_bytes(MAC, 0, 10, 0, -1, 1'b0);
        put_beat(1'b1, 1'b1, fbyte(MAC, 0), 1'b0);
        idle_beat();
        sample();
        chk("pend.out_error", obs_oerr, 32'd1);
        exp_status("pend_abort", 0, 5, 10);
        idle_beat();
        sample();
        exp_status("pend_runt", 0, 2, 1);
        idle_beat();
        chk("pend.status_valid_off", 32'(status_valid), 32'd0);
        exp_counts("pend", 1, 2, 1, 0, 0);

        send_frame(MAC, 64, -1, 1'b1);
        chk("stall_good.out_error", obs_oerr, 32'd0);
        exp_status("stall_good", 1, 0, 64);
        send_frame(OTH, 64, -1, 1'b1);
        chk("stall_filt.out_error", obs_oerr, 32'd1);
        exp_status("stall_filt", 0, 4, 64);
        send_frame(MAC, 40, -1, 1'b1);
        exp_status("stall_runt", 0, 2, 40);
        idle_beat();
        exp_counts("stall", 2, 2, 2, 0, 1);

        send_frame(MAC, 64, -1, 1'b0);
        exp_status("clr_hit", 1, 0, 64);
        stats_clr = 1'b1;
        idle_beat();
        stats_clr = 1'b0;
        chk("clr_hit.cnt_good", 32'(cnt_good), 32'd0);

        for (int k = 0; k < 17; k++) send_frame(MAC, 64, -1, 1'b0);
        idle_beat();
        chk("sat.cnt_good", 32'(cnt_good), 32'd15);

        send_bytes(MAC, 0, 20, 0, -1, 1'b0);
        @(negedge mac_clk);
        in_valid = 1'b0; mac_rst = 1'b1;
        @(negedge mac_clk);
        mac_rst = 1'b0;
        chk("midrst.status_valid", 32'(status_valid), 32'd0);
        chk("midrst.cnt_good", 32'(cnt_good), 32'd0);
        idle_beat();
        chk("midrst.status_valid2", 32'(status_valid), 32'd0);
        put_beat(1'b1, 1'b0, fbyte(MAC, 0), 1'b0);
        put_beat(1'b0, 1'b0, fbyte(MAC, 1), 1'b0);
        chk("midrst.no_abort", 32'(status_valid), 32'd0);
        send_bytes(MAC, 2, 64, 64, -1, 1'b0);
        idle_beat();
        sample();
        exp_status("midrst_next", 1, 0, 64);
        idle_beat();
        chk("midrst.cnt_good_after", 32'(cnt_good), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side frame controller between the CRC-checked RX byte stream and the downstream packet buffer.
- Tracks frame boundaries and counts length, applying these checks to each frame:
  - destination-address filter (unicast, broadcast, multicast, promiscuous)
  - runt and giant length limits
  - error flag
- At end of frame, issues a single accept/drop verdict with a reason code.
- Re-times the stream by one cycle. Forces error on the eop beat of rejected frames. Keeps saturating statistics counters.

Parameters:
- DATA_WIDTH, 8, stream data width; only 8 supported.
- MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- mac_clk  in  1  single clock for all logic.
- mac_rst  in  1  synchronous reset, active-high.
- in_startofpacket  in  1  first byte of frame.
- in_endofpacket  in  1  last byte of frame (last FCS byte).
- in_valid  in  1  beat qualifier; no backpressure exists.
- in_data  in  DATA_WIDTH  frame byte.
- in_error  in  1  error flag (PHY/CRC); may assert on any beat.
- out_startofpacket / out_endofpacket / out_valid / out_data / out_error  out  1/1/1/DATA_WIDTH/1  registered copy of the input stream.
- local_mac  in  48  station address; first byte on the wire = bits [47:40].
- max_len  in  16  maximum legal length in bytes (e.g. 1518).
- promisc  in  1  accept any DA.
- accept_mcast  in  1  accept multicast DA (first DA byte bit0=1, not broadcast).
- status_valid  out  1  one-cycle verdict pulse.
- status_accept  out  1  1 = frame good.
- status_reason  out  3  0 OK, 1 ERROR, 2 RUNT, 3 GIANT, 4 FILTERED, 5 ABORT.
- status_len  out  16  frame byte count, saturating at 0xFFFF.
- stats_clr  in  1  clears all counters.
- cnt_good / cnt_bad / cnt_runt / cnt_giant / cnt_filtered  out  CNT_WIDTH each  saturating frame counters.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, length = 0, flags cleared. Reset mid-frame discards the frame with no status pulse.
- Beats with in_valid=0 are ignored and change no state.
- Output stream: every field is registered, so latency is 1 cycle.
  - out_error = in_error on all beats except the eop beat.
  - On the eop beat, out_error = in_error OR (verdict != OK).
- Verdict logic is combinational from current state plus the eop beat, so it is available on the eop beat itself.
- FSM states: IDLE, DA, BODY.
  - IDLE: valid+sop → DA, len=1, da_idx=1, capture byte 0 match flags. Valid beats without sop are dropped silently.
  - DA: compare each byte against local_mac and 0xFF, accumulating uc_match and bc_match. After byte 5 (da_idx=5) → BODY. Byte 0 bit0 sets the mcast flag.
  - BODY: count bytes.
  - Any state, valid+eop → IDLE, emitting status on the next cycle. A frame ending inside DA (fewer than 6 bytes) is a RUNT.
  - In DA or BODY, valid+sop without a prior eop:
    - emit status for the old frame: reason ABORT, len = count so far;
    - start the new frame in DA with len=1.
    - Same cycle with eop too: treat as a 1-byte frame. Status for the abort goes out first; the 1-byte RUNT status goes out the following cycle (one-entry pending register).
- Error flag: sticky, set by in_error on any beat of the frame, cleared at sop.
- Length: len increments per valid beat and saturates at 0xFFFF. Giant if len > max_len.
- Address accept = promisc | uc_match | bc_match | (mcast & accept_mcast).
- Reason priority: ERROR > RUNT (len < MIN_LEN) > GIANT > FILTERED > OK. status_accept = (reason == OK).
- status_valid is registered: it asserts the cycle after the eop beat, with reason and len held for that cycle only.
- Counters, updated on the status_valid cycle:
  - OK → cnt_good; ERROR or ABORT → cnt_bad; RUNT → cnt_runt; GIANT → cnt_giant; FILTERED → cnt_filtered.
  - Each saturates at all-ones and never wraps.
  - stats_clr has priority: if it coincides with an increment, the counter becomes 0 and that event is lost.

Test Plan:
- 64-byte frame, DA = local_mac = 02:00:00:00:00:01, no error → eop beat out_error=0; next cycle status_valid=1, accept=1, reason=0, len=64; cnt_good=1.
- 64-byte frame, DA = 02:00:00:00:00:02, promisc=0 → reason=4, out_error=1 on the eop output beat, cnt_filtered=1. Repeat with promisc=1 → accept=1.
- Frames with DA FF:FF:FF:FF:FF:FF and 01:00:5E:00:00:01 with accept_mcast=0 → broadcast accepted; multicast reason=4. With accept_mcast=1 → both accepted.
- 40-byte frame with in_error on byte 20 → reason=1 (ERROR beats RUNT), cnt_bad=1. 40-byte clean frame → reason=2. 1519-byte frame with max_len=1518 → reason=3, len=1519.
- sop at byte 30 of a frame with no eop, then a 64-byte good frame → status reason=5 with len=30, then an OK status with len=64; cnt_bad=1, cnt_good=1.
- Stall beats (in_valid=0 between every byte) → results identical to back-to-back.
- Force cnt_good to all-ones → stays all-ones.
- stats_clr coincident with a good-frame status → cnt_good=0.
- mac_rst mid-frame → no status pulse; next frame is judged correctly.
